// File: rtl/hall_decoder.sv
// BLDC hall sensor front end: synchronise, debounce and decode the 6-step sector,
// then track direction, signed position, step period, stalls and illegal codes.
module hall_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 24,
  parameter int PERIOD_WIDTH    = 24,
  parameter int TIMEOUT         = 16000000
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          hall1,
  input  logic                          hall2,
  input  logic                          hall3,
  output logic [2:0]                    sector,
  output logic                          sector_valid,
  output logic                          direction,
  output logic                          step_strobe,
  output logic signed [COUNT_WIDTH-1:0] position,
  output logic [PERIOD_WIDTH-1:0]       period,
  output logic                          period_valid,
  output logic                          stalled,
  output logic                          hall_error,
  output logic                          skip_error
);

  localparam int                    DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]       DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]       DB_ACC = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PERIOD_WIDTH-1:0] TO_C = PERIOD_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  logic [2:0]                    sync1_q, sync2_q, prev_q, acc_q, acc_d;
  logic [DB_W-1:0]               db_cnt_q, db_cnt_d;
  logic                          accept;
  state_t                        state_q, state_d;
  logic [2:0]                    sector_q, sector_d;
  logic                          sec_valid_q, sec_valid_d;
  logic                          dir_q, dir_d;
  logic                          strobe_q, strobe_d;
  logic signed [COUNT_WIDTH-1:0] pos_q, pos_d;
  logic [PERIOD_WIDTH-1:0]       period_q, period_d;
  logic [PERIOD_WIDTH-1:0]       per_cnt_q, per_cnt_d;
  logic                          per_valid_q, per_valid_d;
  logic                          have_dir_q, have_dir_d;
  logic                          stalled_q, stalled_d;
  logic                          herr_q, herr_d;
  logic                          skip_q, skip_d;
  logic [3:0]                    dec;
  logic [3:0]                    diff;
  logic                          step_fwd, step_rev;

  // Returns {legal, sector}; 000 and 111 are the only illegal codes.
  function automatic logic [3:0] sector_of(input logic [2:0] code);
    case (code)
      3'b101:  return 4'b1_000;
      3'b100:  return 4'b1_001;
      3'b110:  return 4'b1_010;
      3'b010:  return 4'b1_011;
      3'b011:  return 4'b1_100;
      3'b001:  return 4'b1_101;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] v);
    return (v >= TO_C) ? TO_C : v + 1'b1;
  endfunction

  always_comb begin
    db_cnt_d = db_cnt_q;
    if (sync2_q != prev_q)
      db_cnt_d = '0;
    else if (db_cnt_q != DB_MAX)
      db_cnt_d = db_cnt_q + 1'b1;
    accept = (sync2_q == prev_q) && (db_cnt_q >= DB_ACC) && (sync2_q != acc_q);
    acc_d  = accept ? sync2_q : acc_q;
  end

  always_comb begin
    state_d     = state_q;
    sector_d    = sector_q;
    sec_valid_d = sec_valid_q;
    dir_d       = dir_q;
    strobe_d    = 1'b0;
    pos_d       = pos_q;
    period_d    = period_q;
    per_cnt_d   = sat_inc(per_cnt_q);
    per_valid_d = per_valid_q;
    have_dir_d  = have_dir_q;
    stalled_d   = stalled_q;
    herr_d      = herr_q;
    skip_d      = 1'b0;
    step_fwd    = 1'b0;
    step_rev    = 1'b0;
    dec         = sector_of(sync2_q);
    diff        = {1'b0, dec[2:0]} + 4'd6 - {1'b0, sector_q};
    if (diff >= 4'd6)
      diff = diff - 4'd6;

    if (accept) begin
      if (!dec[3]) begin
        herr_d      = 1'b1;
        sec_valid_d = 1'b0;
        state_d     = S_FAULT;
      end else if (state_q == S_INIT) begin
        sector_d    = dec[2:0];
        sec_valid_d = 1'b1;
        state_d     = S_RUN;
      end else begin
        // FAULT recovery is judged against the sector held through the fault.
        herr_d      = 1'b0;
        sec_valid_d = 1'b1;
        sector_d    = dec[2:0];
        state_d     = S_RUN;
        case (diff)
          4'd0: ;
          4'd1: step_fwd = 1'b1;
          4'd5: step_rev = 1'b1;
          default: begin
            skip_d      = 1'b1;
            per_valid_d = 1'b0;
            have_dir_d  = 1'b0;
            per_cnt_d   = PERIOD_WIDTH'(1);
          end
        endcase
      end
    end

    // A step wins over a simultaneous timeout, so stalled never rises with it.
    if (step_fwd || step_rev) begin
      strobe_d    = 1'b1;
      dir_d       = step_rev;
      pos_d       = step_rev ? pos_q - COUNT_WIDTH'(1) : pos_q + COUNT_WIDTH'(1);
      period_d    = per_cnt_q;
      per_valid_d = have_dir_q && (dir_q == step_rev);
      have_dir_d  = 1'b1;
      per_cnt_d   = PERIOD_WIDTH'(1);
      stalled_d   = 1'b0;
    end else if (per_cnt_q >= TO_C) begin
      stalled_d   = 1'b1;
      per_valid_d = 1'b0;
      have_dir_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      acc_q       <= '0;
      db_cnt_q    <= '0;
      state_q     <= S_INIT;
      sector_q    <= '0;
      sec_valid_q <= 1'b0;
      dir_q       <= 1'b0;
      strobe_q    <= 1'b0;
      pos_q       <= '0;
      period_q    <= '0;
      per_cnt_q   <= '0;
      per_valid_q <= 1'b0;
      have_dir_q  <= 1'b0;
      stalled_q   <= 1'b0;
      herr_q      <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      // Stage boundary: raw pins -> two-flop synchroniser -> debounce history.
      sync1_q     <= {hall1, hall2, hall3};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      acc_q       <= acc_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      sector_q    <= sector_d;
      sec_valid_q <= sec_valid_d;
      dir_q       <= dir_d;
      strobe_q    <= strobe_d;
      pos_q       <= pos_d;
      period_q    <= period_d;
      per_cnt_q   <= per_cnt_d;
      per_valid_q <= per_valid_d;
      have_dir_q  <= have_dir_d;
      stalled_q   <= stalled_d;
      herr_q      <= herr_d;
      skip_q      <= skip_d;
    end
  end

  assign sector       = sector_q;
  assign sector_valid = sec_valid_q;
  assign direction    = dir_q;
  assign step_strobe  = strobe_q;
  assign position     = pos_q;
  assign period       = period_q;
  assign period_valid = per_valid_q;
  assign stalled      = stalled_q;
  assign hall_error   = herr_q;
  assign skip_error   = skip_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Bench for hall_decoder: directed scenarios plus randomized hall sequences
// compared every cycle against a sample-window reference model.
module tb_hall_decoder;

  localparam int N  = 4;
  localparam int TO = 1000;
  localparam int CW = 8;
  localparam int PW = 12;
  localparam logic [2:0] FWD [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  logic          clk = 1'b0;
  logic          reset;
  logic          hall1, hall2, hall3;
  logic [2:0]    sector;
  logic          sector_valid, direction, step_strobe;
  logic [CW-1:0] position;
  logic [PW-1:0] period;
  logic          period_valid, stalled, hall_error, skip_error;

  always #5 clk = ~clk;

  hall_decoder #(
    .DEBOUNCE_CYCLES(N), .COUNT_WIDTH(CW), .PERIOD_WIDTH(PW), .TIMEOUT(TO)
  ) dut (
    .CLK(clk), .reset(reset), .hall1(hall1), .hall2(hall2), .hall3(hall3),
    .sector(sector), .sector_valid(sector_valid), .direction(direction),
    .step_strobe(step_strobe), .position(position), .period(period),
    .period_valid(period_valid), .stalled(stalled), .hall_error(hall_error),
    .skip_error(skip_error)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_strobe = 0;
  int n_skip   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int sec_of(input logic [2:0] c);
    for (int i = 0; i < 6; i++)
      if (FWD[i] == c) return i;
    return -1;
  endfunction

  // Reference model: a code is taken when the last N+1 pin samples, seen two
  // clocks late through the synchroniser, agree and differ from the last taken code.
  logic [2:0] hist [N+3];
  logic [2:0] m_acc;
  int  m_sector, m_pos, m_period, m_cnt, m_last_dir;
  bit  m_started, m_sv, m_dir, m_strobe, m_pv, m_stalled, m_herr, m_skip;

  always @(posedge clk) begin
    logic [2:0] c;
    int  s, d, sd, old;
    bit  ok, stepped, skipped;
    if (reset) begin
      for (int i = 0; i < N + 3; i++) hist[i] = 3'b000;
      m_acc = 3'b000; m_sector = 0; m_pos = 0; m_period = 0; m_cnt = 0;
      m_last_dir = -1; m_started = 0; m_sv = 0; m_dir = 0; m_strobe = 0;
      m_pv = 0; m_stalled = 0; m_herr = 0; m_skip = 0;
    end else begin
      for (int i = N + 2; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {hall1, hall2, hall3};
      c  = hist[2];
      ok = (c != m_acc);
      for (int i = 3; i <= N + 2; i++)
        if (hist[i] != c) ok = 0;
      m_strobe = 0; m_skip = 0; stepped = 0; skipped = 0; sd = 0;
      if (ok) begin
        m_acc = c;
        s = sec_of(c);
        if (s < 0) begin
          m_herr = 1; m_sv = 0; m_started = 1;
        end else if (!m_started) begin
          m_sector = s; m_sv = 1; m_started = 1;
        end else begin
          m_herr = 0; m_sv = 1;
          d = (s - m_sector + 6) % 6;
          m_sector = s;
          if (d == 1) begin stepped = 1; sd = 0; end
          else if (d == 5) begin stepped = 1; sd = 1; end
          else if (d != 0) skipped = 1;
        end
      end
      old = m_cnt;
      if (stepped) begin
        m_strobe = 1;
        m_period = old;
        m_pv = (m_last_dir == sd);
        m_last_dir = sd;
        m_dir = (sd == 1);
        m_pos = m_pos + ((sd == 1) ? -1 : 1);
        m_cnt = 1;
        m_stalled = 0;
      end else begin
        if (skipped) begin
          m_skip = 1; m_pv = 0; m_last_dir = -1; m_cnt = 1;
        end else begin
          m_cnt = (old >= TO) ? TO : old + 1;
        end
        if (old >= TO) begin
          m_stalled = 1; m_pv = 0; m_last_dir = -1;
        end
      end
    end
  end

  logic [29:0] dut_vec, mdl_vec;
  assign dut_vec = {sector, sector_valid, direction, step_strobe, position, period,
                    period_valid, stalled, hall_error, skip_error};
  always_comb
    mdl_vec = {3'(m_sector), m_sv, m_dir, m_strobe, CW'(m_pos), PW'(m_period),
               m_pv, m_stalled, m_herr, m_skip};

  always @(negedge clk) begin
    if (!reset) begin
      chk("outputs_vs_model", 64'(dut_vec), 64'(mdl_vec));
      if (step_strobe) n_strobe++;
      if (skip_error)  n_skip++;
    end
  end

  task automatic drive(input logic [2:0] c, input int n);
    {hall1, hall2, hall3} = c;
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    logic [2:0] cur, nxt, g;
    int r, len, s;
    reset = 1'b1;
    {hall1, hall2, hall3} = 3'b101;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_state", 64'(dut_vec), 64'(0));
    reset = 1'b0;

    drive(3'b101, 6);
    chk("first_code_latency_sv", 64'(sector_valid), 64'(0));
    drive(3'b101, 1);
    chk("first_code_sv", 64'(sector_valid), 64'(1));
    chk("first_code_sector", 64'(sector), 64'(0));
    chk("first_code_pos", 64'(position), 64'(0));
    chk("first_code_strobes", 64'(n_strobe), 64'(0));

    for (int i = 0; i < 6; i++) begin
      drive(FWD[(i + 1) % 6], 200);
      chk("fwd_pv", 64'(period_valid), 64'((i == 0) ? 0 : 1));
    end
    chk("fwd_pos", 64'(position), 64'(6));
    chk("fwd_dir", 64'(direction), 64'(0));
    chk("fwd_period", 64'(period), 64'(200));
    chk("fwd_strobes", 64'(n_strobe), 64'(6));

    drive(3'b001, 150);
    chk("rev1_pv", 64'(period_valid), 64'(0));
    chk("rev1_dir", 64'(direction), 64'(1));
    chk("rev1_pos", 64'(position), 64'(5));
    chk("rev1_period", 64'(period), 64'(200));
    drive(3'b011, 150);
    chk("rev2_pv", 64'(period_valid), 64'(1));
    chk("rev2_period", 64'(period), 64'(150));
    chk("rev2_pos", 64'(position), 64'(4));

    drive(3'b001, 3);
    drive(3'b011, 20);
    chk("glitch_sector", 64'(sector), 64'(4));
    chk("glitch_pos", 64'(position), 64'(4));
    chk("glitch_strobes", 64'(n_strobe), 64'(8));
    drive(3'b000, 20);
    chk("illegal_herr", 64'(hall_error), 64'(1));
    chk("illegal_sv", 64'(sector_valid), 64'(0));
    chk("illegal_sector", 64'(sector), 64'(4));
    drive(3'b001, 20);
    chk("recover_herr", 64'(hall_error), 64'(0));
    chk("recover_sv", 64'(sector_valid), 64'(1));
    chk("recover_pos", 64'(position), 64'(5));

    n_skip = 0;
    drive(3'b110, 20);
    chk("skip_pulses", 64'(n_skip), 64'(1));
    chk("skip_sector", 64'(sector), 64'(2));
    chk("skip_pos", 64'(position), 64'(5));
    chk("skip_pv", 64'(period_valid), 64'(0));

    drive(3'b110, 1100);
    chk("stall_set", 64'(stalled), 64'(1));
    chk("stall_pv", 64'(period_valid), 64'(0));
    drive(3'b010, 20);
    chk("stall_clear", 64'(stalled), 64'(0));
    chk("stall_step_pos", 64'(position), 64'(6));
    chk("stall_step_period", 64'(period), 64'(TO));

    {hall1, hall2, hall3} = 3'b011;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", 64'(dut_vec), 64'(0));
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    drive(3'b011, 6);
    chk("reinit_latency_sv", 64'(sector_valid), 64'(0));
    drive(3'b011, 1);
    chk("reinit_sector", 64'(sector), 64'(4));
    chk("reinit_pos", 64'(position), 64'(0));

    cur = 3'b011;
    for (int k = 0; k < 300; k++) begin
      r   = int'($urandom_range(0, 99));
      len = int'($urandom_range(N + 4, 60));
      s   = sec_of(cur);
      if (s < 0) s = 0;
      nxt = cur;
      if (r < 45)      nxt = FWD[(s + 1) % 6];
      else if (r < 65) nxt = FWD[(s + 5) % 6];
      else if (r < 75) nxt = FWD[(s + int'($urandom_range(2, 4))) % 6];
      else if (r < 80) nxt = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
      else if (r < 97) begin
        g = 3'($urandom_range(0, 7));
        drive(g, int'($urandom_range(1, N - 1)));
      end else
        len = 1100;
      drive(nxt, len);
      cur = nxt;
    end

    for (int k = 0; k < 140; k++) begin
      s = sec_of(cur);
      if (s < 0) s = 0;
      nxt = FWD[(s + 1) % 6];
      drive(nxt, N + 5);
      cur = nxt;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
